// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues read-only requests to the instruction
// mem_system and buffers returned words in a 2-entry queue for decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    input  logic        id_stall,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_done,
    input  logic        mem_err,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam int DEPTH = 2;

    state_t      state_reg;
    logic [15:0] fetch_pc_reg;
    logic [15:0] pend_pc_reg;
    logic        squash_reg;
    logic        mem_rd_reg;
    logic        fetch_err_reg;
    logic [1:0]  occ_reg;
    logic [1:0]  occ_next;
    logic        head_reg;

    logic        in_err;
    logic        done_ok;
    logic        capture;
    logic        dequeue;
    logic        flush;
    logic        start_ok;
    logic        tail;

    logic [15:0] entry_instr [DEPTH];
    logic [15:0] entry_pc    [DEPTH];

    always_comb begin
        in_err   = (state_reg == ERR);
        done_ok  = (state_reg == REQ) && mem_done && !mem_err;
        capture  = done_ok && !squash_reg && !redirect;
        dequeue  = instr_valid && !id_stall && !in_err;
        flush    = redirect && !in_err;
        occ_next = 2'd0;
        if (!flush) begin
            occ_next = occ_reg + {1'b0, capture} - {1'b0, dequeue};
        end
        start_ok = !halt && (occ_next <= 2'd1);
        // A capture only happens with at most one entry resident, so the
        // slot after the head is always free.
        tail     = head_reg ^ occ_reg[0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [15:0] instr_reg;
            logic [15:0] pc_reg;

            always_ff @(posedge clk) begin
                if (capture && (tail == 1'(gi))) begin
                    instr_reg <= mem_data_out;
                    pc_reg    <= fetch_pc_reg;
                end
            end

            assign entry_instr[gi] = instr_reg;
            assign entry_pc[gi]    = pc_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            fetch_pc_reg  <= RESET_PC;
            pend_pc_reg   <= RESET_PC;
            squash_reg    <= 1'b0;
            mem_rd_reg    <= 1'b0;
            fetch_err_reg <= 1'b0;
            occ_reg       <= 2'd0;
            head_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_pc;
                    end
                    if (start_ok) begin
                        state_reg  <= REQ;
                        mem_rd_reg <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_err) begin
                        state_reg     <= ERR;
                        mem_rd_reg    <= 1'b0;
                        fetch_err_reg <= 1'b1;
                        squash_reg    <= 1'b0;
                    end else if (mem_done) begin
                        if (redirect) begin
                            fetch_pc_reg <= redirect_pc;
                        end else if (squash_reg) begin
                            fetch_pc_reg <= pend_pc_reg;
                        end else begin
                            fetch_pc_reg <= fetch_pc_reg + 16'd2;
                        end
                        squash_reg <= 1'b0;
                        state_reg  <= start_ok ? REQ : IDLE;
                        mem_rd_reg <= start_ok;
                    end else if (redirect) begin
                        // Address must stay put until Done; remember the target.
                        squash_reg  <= 1'b1;
                        pend_pc_reg <= redirect_pc;
                    end
                end
                ERR: begin
                    mem_rd_reg <= 1'b0;
                end
                default: begin
                    state_reg  <= IDLE;
                    mem_rd_reg <= 1'b0;
                end
            endcase

            if (!in_err) begin
                occ_reg <= occ_next;
                if (dequeue && !flush) begin
                    head_reg <= ~head_reg;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (occ_reg <= 2'd2);
        end
    end

    assign mem_addr    = fetch_pc_reg;
    assign mem_rd      = mem_rd_reg;
    assign mem_wr      = 1'b0;
    assign mem_data_in = 16'h0000;
    assign instr       = entry_instr[head_reg];
    assign instr_pc    = entry_pc[head_reg];
    assign instr_valid = (occ_reg != 2'd0);
    assign fetch_err   = fetch_err_reg;

endmodule
